scope_buf: RTL and testbench
============================

// Module: scope_buf
// PURPOSE
//  Capture buffer downstream of the scope acquisition stream: writes every accepted sample into a
//  circular BRAM and freezes on TLAST (end of acquisition). Software reads buffer contents, write
//  pointer, last-sample pointer and status over a sys-bus-style register/memory window.
// PARAMETERS
//  DW   14  sample width (signed)
//  AW   14  buffer address width; depth = 2**AW samples
// PORTS
//  clk         in   1   clock; single clock domain
//  rst         in   1   synchronous reset, active high
//  sti_tdata   in   DW  sample, signed
//  sti_tvalid  in   1   sample valid
//  sti_tlast   in   1   last sample of acquisition
//  sti_tready  out  1   buffer accepts sample
//  bus_wen     in   1   bus write strobe (1 cycle)
//  bus_ren     in   1   bus read strobe (1 cycle)
//  bus_addr    in   32  byte address
//  bus_wdata   in   32  write data
//  bus_rdata   out  32  read data, valid with bus_ack
//  bus_ack     out  1   access done
//  bus_err     out  1   access error
// BEHAVIOUR
//  Reset (rst=1 at posedge): wp=0, lst=0, wrp=0, end=0, bus_ack=0, bus_err=0, bus_rdata=0.
//    RAM contents are not cleared. After reset, sti_tready=1.
//  sti_tready = ~end & ~clr  (combinational). clr = bus_wen & addr==0x00 & wdata[0].
//    A sample is never dropped on clr; it is back-pressured instead.
//  Transfer (tvalid & tready):
//    - mem[wp] <= tdata; wp <= wp+1 (mod 2**AW).
//    - When wp==2**AW-1, wrp <= 1 (sticky).
//    - With tlast: end <= 1 and lst <= wp (address of the last sample written).
//  clr: wp, lst, wrp, end <= 0 on the next cycle.
//  Memory map, bus_addr[AW+2]=1: RAM window, word index = bus_addr[AW+1:2].
//  Memory map, bus_addr[AW+2]=0 (registers):
//    0x00  W: bit0=clr.                    R: {30'b0, end, wrp}
//    0x04  R: wp (zero-extended)
//    0x08  R: lst (zero-extended)
//    other: R 0, W ignored
//  Read latency:
//    - bus_ack is asserted 2 cycles after bus_ren, for RAM and register reads alike.
//    - Reads use a 2-stage pipeline: RAM read register, then output register.
//  Write latency: bus_ack is asserted 1 cycle after bus_wen.
//  Outstanding accesses:
//    - Only one access may be outstanding.
//    - wen & ren in the same cycle -> bus_err=1 with bus_ack, 2 cycles later; no write takes effect.
//    - A new strobe while a read is pending is ignored.
//  RAM read data is sign-extended from DW to 32 bits.
//  Read of the address currently being written returns the old content (read-first).
//  Pointers wrap silently. After end=1 the buffer holds; only clr or rst re-arms it.
// CONFIGURATION
//  SCOPE_BUF_PACK_EN undefined: one sample per 32-bit word; RAM is 2**AW x DW.
//  SCOPE_BUF_PACK_EN defined:
//    - Two samples per 32-bit word: [15:0] = even address, [31:16] = odd address.
//    - Each sample is sign-extended to 16 bits; requires DW<=16.
//    - RAM is 2**(AW-1) x 2*DW with per-lane write enable selected by wp[0].
//    - RAM window word index = bus_addr[AW:2].
//    - wp, lst, wrp semantics are unchanged (sample granularity).
// STRUCTURE
//  scope_buf_pkg holds:
//    - register offsets: REG_CTL=0x00, REG_WP=0x04, REG_LST=0x08
//    - typedef sts_t {end, wrp}
//    - RAM window select bit function
//  Sub-module scope_buf_ram: simple dual-port BRAM.
//    - 1 write port with lane enables; 1 registered read port, read-first.
//    - Parameterised on AW and word width.
//  Top level: pointer/flag logic, bus decode, 2-stage read pipeline.
// TESTING (AW=4 bench unless noted)
//  1 rst then idle -> tready=1; read 0x00, 0x04, 0x08 = 0; each ack exactly 2 cycles after ren.
//  2 stream 0..9, tlast on 9 -> end=1, lst=9, wp=10, tready=0 from next cycle;
//    RAM word 3 reads 0x00000003.
//  3 stream 21 samples, no tlast -> wrp=1, wp=5; RAM word 0 holds sample 16.
//  4 sample -8192 (0x2000) at addr 0 -> RAM read = 0xFFFFE000.
//  5 clr write in the same cycle as tvalid=1 -> tready=0 that cycle; next cycle wp=0, end=0,
//    sample accepted at addr 0.
//  6 PACK_EN: samples 1, -1 -> RAM word 0 = 0xFFFF0001; wen&ren together -> err=1, no write.

Source files
------------

// File: rtl/scope_buf_pkg.sv
// scope_buf_pkg: shared definitions for the scope capture buffer.
//   - register offsets of the sys-bus register window
//   - sts_t status flags {done, wrp}
//   - ram_sel(): picks the RAM window versus the register window from a byte address
package scope_buf_pkg;

  localparam logic [7:0] REG_CTL = 8'h00;
  localparam logic [7:0] REG_WP  = 8'h04;
  localparam logic [7:0] REG_LST = 8'h08;

  // done: acquisition ended on TLAST, buffer frozen
  // wrp : write pointer has wrapped at least once
  typedef struct packed {
    logic done;
    logic wrp;
  } sts_t;

  // Byte address bit AW+2 selects the RAM window.
  function automatic logic ram_sel(input logic [31:0] addr, input int aw);
    return addr[aw+2];
  endfunction

endpackage

// File: rtl/scope_buf_if.sv
// scope_buf_if: groups the sample stream and sys-bus signals of scope_buf.
//   sti_*  : sample stream (tdata/tvalid/tlast in, tready out of the buffer)
//   bus_*  : register/memory access window (wen/ren/addr/wdata in, rdata/ack/err out)
// master drives the stream and the bus strobes; slave is the buffer.
interface scope_buf_if #(parameter int DW = 14);
  logic signed [DW-1:0] sti_tdata;
  logic                 sti_tvalid;
  logic                 sti_tlast;
  logic                 sti_tready;
  logic                 bus_wen;
  logic                 bus_ren;
  logic [31:0]          bus_addr;
  logic [31:0]          bus_wdata;
  logic [31:0]          bus_rdata;
  logic                 bus_ack;
  logic                 bus_err;

  modport master (
    output sti_tdata, sti_tvalid, sti_tlast, bus_wen, bus_ren, bus_addr, bus_wdata,
    input  sti_tready, bus_rdata, bus_ack, bus_err
  );
  modport slave (
    input  sti_tdata, sti_tvalid, sti_tlast, bus_wen, bus_ren, bus_addr, bus_wdata,
    output sti_tready, bus_rdata, bus_ack, bus_err
  );
endinterface

// File: rtl/scope_buf_ram.sv
// scope_buf_ram: simple dual-port RAM, 2**AW words of WW bits split into NL lanes.
//   clk          clock
//   we[NL]       per-lane write enable, waddr/wdata write port
//   re, raddr    registered read port, rdata valid the cycle after re
// Read-first: a read and write of the same word on one edge returns the old word.
module scope_buf_ram #(
  parameter int AW = 14,
  parameter int WW = 14,
  parameter int NL = 1
) (
  input  logic          clk,
  input  logic [NL-1:0] we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);
  localparam int LW = WW / NL;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic [LW-1:0] mem [2**AW];
    logic [LW-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (we[g]) mem[waddr] <= wdata[g*LW +: LW];
      if (re)    rd_q       <= mem[raddr];
    end
    assign rdata[g*LW +: LW] = rd_q;
  end
endmodule

// File: rtl/scope_buf.sv
// scope_buf: circular capture buffer for the scope acquisition stream.
// Every accepted sample goes to RAM at wp; TLAST freezes the buffer (done=1) and
// records its address in lst. Software reads RAM, wp, lst and status over the bus.
//   clk, rst   single clock, synchronous active-high reset
//   sb         scope_buf_if.slave: sample stream + bus window
// Bus map: addr[AW+2]=1 RAM window; else 0x00 CTL (W bit0=clr, R {done,wrp}),
// 0x04 wp, 0x08 lst, others read 0. Reads ack after 2 cycles, writes after 1.
// Option SCOPE_BUF_PACK_EN: two 16-bit sign-extended samples per RAM-window word.
module scope_buf
  import scope_buf_pkg::*;
#(
  parameter int DW = 14,
  parameter int AW = 14
) (
  input logic         clk,
  input logic         rst,
  scope_buf_if.slave  sb
);
`ifdef SCOPE_BUF_PACK_EN
  localparam int RAW = AW - 1;
  localparam int NL  = 2;
`else
  localparam int RAW = AW;
  localparam int NL  = 1;
`endif
  localparam int WW = NL * DW;

  logic [AW-1:0]  wp, lst;
  sts_t           sts;
  logic           in_ram, acc, rd_go, wr_go, err_go, clr, xfer;
  logic           s1_vld, s1_err, s1_ram;
  logic [31:0]    s1_reg, reg_rd, ram_word;
  logic [NL-1:0]  ram_we;
  logic [RAW-1:0] ram_waddr, ram_raddr;
  logic [WW-1:0]  ram_wdata, ram_rdata;
  logic           unused_wdata;

  assign unused_wdata = ^sb.bus_wdata[31:1];

  // One access outstanding: strobes arriving while a read sits in stage 1 are dropped.
  assign in_ram = ram_sel(sb.bus_addr, AW);
  assign acc    = (sb.bus_wen | sb.bus_ren) & ~s1_vld;
  assign rd_go  = acc & sb.bus_ren;
  assign err_go = acc & sb.bus_wen & sb.bus_ren;
  assign wr_go  = acc & sb.bus_wen & ~sb.bus_ren;
  assign clr    = wr_go & (sb.bus_addr == 32'(REG_CTL)) & sb.bus_wdata[0];

  // Back-pressure during clr so the sample lands at address 0 after re-arm.
  assign sb.sti_tready = ~sts.done & ~clr;
  assign xfer          = sb.sti_tvalid & sb.sti_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      lst <= '0;
      sts <= '0;
    end else if (clr) begin
      wp  <= '0;
      lst <= '0;
      sts <= '0;
    end else if (xfer) begin
      wp <= wp + AW'(1);
      if (&wp) sts.wrp <= 1'b1;
      if (sb.sti_tlast) begin
        sts.done <= 1'b1;
        lst      <= wp;
      end
    end
  end

`ifdef SCOPE_BUF_PACK_EN
  assign ram_we    = xfer ? (wp[0] ? 2'b10 : 2'b01) : 2'b00;
  assign ram_waddr = wp[AW-1:1];
  assign ram_wdata = {2{sb.sti_tdata}};
  assign ram_raddr = sb.bus_addr[AW:2];
  assign ram_word  = {16'(signed'(ram_rdata[2*DW-1:DW])), 16'(signed'(ram_rdata[DW-1:0]))};
`else
  assign ram_we    = xfer;
  assign ram_waddr = wp;
  assign ram_wdata = sb.sti_tdata;
  assign ram_raddr = sb.bus_addr[AW+1:2];
  assign ram_word  = 32'(signed'(ram_rdata));
`endif

  scope_buf_ram #(.AW(RAW), .WW(WW), .NL(NL)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_go & in_ram & ~sb.bus_wen),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    reg_rd = '0;
    if (sb.bus_addr == 32'(REG_CTL))      reg_rd = {30'b0, sts.done, sts.wrp};
    else if (sb.bus_addr == 32'(REG_WP))  reg_rd = 32'(wp);
    else if (sb.bus_addr == 32'(REG_LST)) reg_rd = 32'(lst);
  end

  // Stage 1 runs in parallel with the RAM read register so register and RAM
  // reads share the same 2-cycle latency; stage 2 is the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld       <= 1'b0;
      s1_err       <= 1'b0;
      s1_ram       <= 1'b0;
      s1_reg       <= '0;
      sb.bus_ack   <= 1'b0;
      sb.bus_err   <= 1'b0;
      sb.bus_rdata <= '0;
    end else begin
      s1_vld     <= rd_go;
      s1_err     <= err_go;
      s1_ram     <= in_ram;
      s1_reg     <= reg_rd;
      sb.bus_ack <= s1_vld | wr_go;
      sb.bus_err <= s1_vld & s1_err;
      if (s1_vld)     sb.bus_rdata <= s1_err ? '0 : (s1_ram ? ram_word : s1_reg);
      else if (wr_go) sb.bus_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_scope_buf.sv
// tb_scope_buf: randomized + directed bench for scope_buf (AW=4, DW=14).
// Stimulus pushes expected bus responses into a queue; a monitor pops and compares
// on every bus_ack. Expected values come from a sample-level model of the buffer.
module tb_scope_buf;
  localparam int DW = 14;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scope_buf_if #(.DW(DW)) sb_if ();
  scope_buf #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .sb(sb_if));

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    bit          chk_data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, rd_free = 0;

  // Reference model: sample-granular buffer state
  int m_mem [DEPTH];
  bit m_vld [DEPTH];
  int m_wp = 0, m_lst = 0;
  bit m_wrp = 0, m_end = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] ram_addr(input int w);
    return 32'((1 << (AW + 2)) + 4 * w);
  endfunction

  function automatic bit word_known(input int w);
`ifdef SCOPE_BUF_PACK_EN
    return m_vld[2*w] && m_vld[2*w+1];
`else
    return m_vld[w];
`endif
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int w, lo, hi;
    if (a[AW+2]) begin
`ifdef SCOPE_BUF_PACK_EN
      w  = int'(a[AW:2]);
      lo = m_mem[2*w];
      hi = m_mem[2*w+1];
      return {hi[15:0], lo[15:0]};
`else
      w  = int'(a[AW+1:2]);
      return m_mem[w];
`endif
    end
    case (a)
      32'h0:   return {30'b0, m_end, m_wrp};
      32'h4:   return m_wp;
      32'h8:   return m_lst;
      default: return 0;
    endcase
  endfunction

  // One clock of stimulus: drive, check tready, queue expected response, advance model.
  task automatic step(input bit tv, input int td, input bit tl, input bit wen, input bit ren,
                      input logic [31:0] addr, input logic [31:0] wd, input string nm);
    bit   acc, clr, rdy;
    int   v;
    exp_t e;
    @(posedge clk); #1;
    sb_if.sti_tvalid = tv;
    sb_if.sti_tdata  = td[DW-1:0];
    sb_if.sti_tlast  = tl;
    sb_if.bus_wen    = wen;
    sb_if.bus_ren    = ren;
    sb_if.bus_addr   = addr;
    sb_if.bus_wdata  = wd;
    acc = (wen || ren) && (cyc >= rd_free);
    clr = acc && wen && !ren && addr == 0 && wd[0];
    rdy = !m_end && !clr;
    #1;
    chk({nm, " tready"}, 32'(sb_if.sti_tready), 32'(rdy));
    if (acc) begin
      e.name = nm;
      if (ren) begin
        e.cyc = cyc + 2; e.err = wen; e.chk_data = !wen;
        e.rdata = wen ? 32'h0 : model_rd(addr);
        rd_free = cyc + 2;
      end else begin
        e.cyc = cyc + 1; e.err = 1'b0; e.chk_data = 1'b0; e.rdata = '0;
      end
      exp_q.push_back(e);
    end
    if (clr) begin
      m_wp = 0; m_lst = 0; m_wrp = 0; m_end = 0;
    end else if (tv && rdy) begin
      v = td[DW-1:0] >= (1 << (DW - 1)) ? int'(td[DW-1:0]) - (1 << DW) : int'(td[DW-1:0]);
      m_mem[m_wp] = v;
      m_vld[m_wp] = 1'b1;
      if (tl) begin m_end = 1'b1; m_lst = m_wp; end
      m_wp = (m_wp + 1) % DEPTH;
      if (m_wp == 0) m_wrp = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 32'h0, "idle");
  endtask

  task automatic rd(input logic [31:0] a, input string nm);
    step(0, 0, 0, 0, 1, a, 32'h0, nm);
    idle(1);
  endtask

  task automatic do_clr();
    step(0, 0, 0, 1, 0, 32'h0, 32'h1, "clr");
  endtask

  // Monitor: every ack must match the oldest expected response at its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb_if.bus_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected ack", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, " ack cycle"}, 32'(cyc), 32'(e.cyc));
            chk({e.name, " err"}, 32'(sb_if.bus_err), 32'(e.err));
            if (e.chk_data) chk({e.name, " rdata"}, sb_if.bus_rdata, e.rdata);
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
          e = exp_q.pop_front();
          chk({e.name, " missing ack"}, 32'h0, 32'h1);
        end
      end
    end
  end

  initial begin
    int k, w, a;
    sb_if.sti_tvalid = 0; sb_if.sti_tdata = '0; sb_if.sti_tlast = 0;
    sb_if.bus_wen = 0; sb_if.bus_ren = 0; sb_if.bus_addr = '0; sb_if.bus_wdata = '0;

    // 1: reset state and register reads
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst ack", 32'(sb_if.bus_ack), 32'h0);
    chk("rst err", 32'(sb_if.bus_err), 32'h0);
    chk("rst rdata", sb_if.bus_rdata, 32'h0);
    chk("rst tready", 32'(sb_if.sti_tready), 32'h1);
    rd(32'h0, "rst ctl"); rd(32'h4, "rst wp"); rd(32'h8, "rst lst");

    // 2: 10 samples ending with tlast, buffer then frozen
    for (int i = 0; i < 10; i++) step(1, i, i == 9, 0, 0, 32'h0, 32'h0, "stream10");
    step(1, 55, 0, 0, 0, 32'h0, 32'h0, "frozen");
    rd(32'h0, "t2 ctl"); rd(32'h4, "t2 wp"); rd(32'h8, "t2 lst"); rd(ram_addr(3), "t2 ram3");

    // 3: 21 samples wrap the 16-deep buffer
    do_clr();
    for (int i = 0; i < 21; i++) step(1, i, 0, 0, 0, 32'h0, 32'h0, "stream21");
    rd(32'h0, "t3 ctl"); rd(32'h4, "t3 wp"); rd(ram_addr(0), "t3 ram0");

    // 4: most negative sample sign-extends
    do_clr();
    step(1, -8192, 0, 0, 0, 32'h0, 32'h0, "neg");
    rd(ram_addr(0), "t4 ram0");

    // 5: clr in the same cycle as tvalid back-pressures, sample lands at 0 next cycle
    step(1, 500, 0, 0, 0, 32'h0, 32'h0, "pre");
    step(1, 77, 0, 1, 0, 32'h0, 32'h1, "clr+tvalid");
    step(1, 77, 0, 0, 0, 32'h0, 32'h0, "after clr");
    rd(32'h4, "t5 wp"); rd(ram_addr(0), "t5 ram0");

    // 6: samples 1,-1; then wen&ren together errors and does not clear
    do_clr();
    step(1, 1, 0, 0, 0, 32'h0, 32'h0, "s1");
    step(1, -1, 0, 0, 0, 32'h0, 32'h0, "s-1");
    rd(ram_addr(0), "t6 ram0");
    step(0, 0, 0, 1, 1, 32'h0, 32'h1, "wen+ren");
    idle(1);
    rd(32'h4, "t6 wp");

    // 7: clr strobe right behind a read is ignored
    step(0, 0, 0, 0, 1, 32'h8, 32'h0, "t7 lst");
    step(0, 0, 0, 1, 0, 32'h0, 32'h1, "ignored clr");
    idle(1);
    rd(32'h4, "t7 wp");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 11);
      if (k == 0) begin
        a = $urandom_range(0, 4) * 4;
        step(($urandom % 3) != 0, $urandom, ($urandom % 40) == 0, 0, 1, 32'(a), 32'h0, "rnd reg");
      end else if (k == 1) begin
`ifdef SCOPE_BUF_PACK_EN
        w = $urandom_range(0, DEPTH / 2 - 1);
`else
        w = $urandom_range(0, DEPTH - 1);
`endif
        step(($urandom % 3) != 0, $urandom, ($urandom % 40) == 0, 0, 1,
             word_known(w) ? ram_addr(w) : 32'h4, 32'h0, "rnd ram");
      end else if (k == 2) begin
        step(($urandom % 3) != 0, $urandom, 0, 1, 0, ($urandom % 2) ? 32'h0 : ram_addr(1),
             32'($urandom), "rnd wr");
      end else if (k == 3) begin
        step(($urandom % 3) != 0, $urandom, 0, 1, 1, 32'h0, 32'h1, "rnd err");
      end else begin
        step(($urandom % 3) != 0, $urandom, ($urandom % 40) == 0, 0, 0, 32'h0, 32'h0, "rnd stream");
      end
    end
    rd(32'h0, "end ctl"); rd(32'h4, "end wp"); rd(32'h8, "end lst");
    idle(5);
    chk("drained queue", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
